// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: MDOp encodings, FSM state encoding, operation latencies,
// counter width and a helper that maps an operation to its latency.
package md_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  // Busy-cycle count for an operation; divides are the slower class.
  function automatic logic [CNT_W-1:0] lat_of(input md_op_e op);
    return (op == MD_DIV || op == MD_DIVU) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational HI/LO arithmetic for the sequencer.
// Ports:
//   a, b      : captured operands (dividend/multiplicand, divisor/multiplier)
//   op        : captured operation
//   result    : {HI,LO}; product for mult/multu, {remainder,quotient} for div/divu
//   div_zero  : divide operation with b == 0 (result must not be committed)
module md_compute
  import md_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] sa, sb, sprod;
  logic        [63:0] uprod;
  logic               is_signed_div;
  logic        [31:0] dvd, dvs, dvs_safe, q, r, q_out, r_out;

  assign sa    = {{32{a[31]}}, a};
  assign sb    = {{32{b[31]}}, b};
  assign sprod = sa * sb;
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes, then fixes signs: quotient negative
  // when operand signs differ, remainder follows the dividend. Doing it on
  // magnitudes keeps 0x80000000 / -1 well defined (wraps back to 0x80000000).
  assign is_signed_div = (op == MD_DIV);
  assign dvd      = (is_signed_div && a[31]) ? (~a + 32'd1) : a;
  assign dvs      = (is_signed_div && b[31]) ? (~b + 32'd1) : b;
  // Avoid a divide by zero in the datapath; the result is discarded anyway.
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q        = dvd / dvs_safe;
  assign r        = dvd % dvs_safe;
  assign q_out    = (is_signed_div && (a[31] ^ b[31])) ? (~q + 32'd1) : q;
  assign r_out    = (is_signed_div && a[31]) ? (~r + 32'd1) : r;

  assign div_zero = (op == MD_DIV || op == MD_DIVU) && (b == 32'd0);

  always_comb begin
    result = {r_out, q_out};
    case (op)
      MD_MULT:  result = sprod;
      MD_MULTU: result = uprod;
      default:  result = {r_out, q_out};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   Start, MDOp     : launch mult/multu/div/divu with operands A, B
//   WriteHL, HLSel  : mthi/mtlo write of A into HI (1) or LO (0)
//   UseHL           : D-stage instruction touches HI/LO (drives Stall)
//   Busy, Stall     : operation in flight; pipeline stall request
//   Done            : one-cycle pulse in the first cycle HI/LO show a result
//   HI, LO          : architectural HI/LO registers
module md_sequencer
  import md_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic        WriteHL,
  input  logic        HLSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        UseHL,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q, b_q;
  md_op_e           op_q;
  logic [63:0]      result;
  logic             div_zero;
  logic             accept, last;

  md_compute u_compute (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (result),
    .div_zero (div_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; counter holds remaining busy cycles, 1 means last.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy   = (state == ST_BUSY);
    accept = (state == ST_IDLE) && Start;
    last   = (state == ST_BUSY) && (cnt == CNT_W'(1));
  end

  assign Stall = UseHL & (Busy | Start);

  // Operand capture, counter and HI/LO. Start outranks WriteHL in IDLE;
  // both are ignored while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= MD_MULT;
      HI   <= '0;
      LO   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= md_op_e'(MDOp);
        cnt  <= lat_of(md_op_e'(MDOp));
      end else if (Busy) begin
        cnt <= cnt - CNT_W'(1);
        if (last) begin
          Done <= 1'b1;
          // Divide by zero still completes and pulses Done, but keeps HI/LO.
          if (!div_zero) begin
            HI <= result[63:32];
            LO <= result[31:0];
          end
        end
      end else if (WriteHL) begin
        if (HLSel) HI <= A;
        else       LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases with literal results
// plus randomized traffic checked every cycle against a behavioural model.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset, Start, WriteHL, HLSel, UseHL;
  logic [1:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Stall, Done;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;

  md_sequencer dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .WriteHL(WriteHL),
    .HLSel(HLSel), .A(A), .B(B), .UseHL(UseHL), .Busy(Busy), .Stall(Stall),
    .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 0;
  int          m_left;
  bit          m_done, m_zero;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;

  always @(posedge clk) begin
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur, up;
    if (reset) begin
      m_valid = 1; m_left = 0; m_done = 0; m_hi = 0; m_lo = 0;
    end else if (m_valid) begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          if (!m_zero) begin m_hi = m_rhi; m_lo = m_rlo; end
        end
      end else if (Start) begin
        sa = longint'($signed(A)); sb = longint'($signed(B));
        ua = {32'd0, A};           ub = {32'd0, B};
        m_zero = 0;
        case (MDOp)
          2'd0: begin sq = sa * sb; m_rhi = sq[63:32]; m_rlo = sq[31:0]; end
          2'd1: begin up = ua * ub; m_rhi = up[63:32]; m_rlo = up[31:0]; end
          2'd2: if (B == 0) m_zero = 1;
                else begin sq = sa / sb; sr = sa % sb; m_rhi = sr[31:0]; m_rlo = sq[31:0]; end
          default: if (B == 0) m_zero = 1;
                else begin uq = ua / ub; ur = ua % ub; m_rhi = ur[31:0]; m_rlo = uq[31:0]; end
        endcase
        m_left = (MDOp[1]) ? 10 : 5;
      end else if (WriteHL) begin
        if (HLSel) m_hi = A; else m_lo = A;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",  Busy,  m_left > 0);
      chk("done",  Done,  m_done);
      chk("hi",    HI,    m_hi);
      chk("lo",    LO,    m_lo);
      chk("stall", Stall, UseHL & ((m_left > 0) | Start));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n = 0;
    Start = 1; MDOp = op; A = a; B = b;
    cyc();
    Start = 0; WriteHL = 0; A = $urandom; B = $urandom;
    while (Busy === 1'b1 && n < 20) begin cyc(); n++; end
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_done"}, Done, 1);
    chk({nm, "_hi"}, HI, ehi);
    chk({nm, "_lo"}, LO, elo);
    cyc();
    chk({nm, "_done_once"}, Done, 0);
  endtask

  initial begin
    reset = 1; Start = 0; WriteHL = 0; HLSel = 0; UseHL = 0;
    MDOp = 0; A = 0; B = 0;
    cyc(); cyc();
    reset = 0;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    cyc();

    run_op("mult",  2'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("divu",  2'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div",   2'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("ovf",   2'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
    run_op("multu", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'd1);

    // mthi/mtlo preset, then divide by zero leaves them intact
    WriteHL = 1; HLSel = 1; A = 32'h11; cyc();
    HLSel = 0; A = 32'h22; cyc();
    WriteHL = 0;
    chk("mthi", HI, 32'h11);
    chk("mtlo", LO, 32'h22);
    chk("mt_nodone", Done, 0);
    run_op("div0", 2'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22);

    // Stall across a mult with Start/WriteHL re-pulsed while busy
    UseHL = 1; Start = 1; MDOp = 0; A = 32'd6; B = 32'd7; #1;
    chk("stall_start", Stall, 1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 2) begin
        Start = 1; WriteHL = 1; HLSel = 0; A = 32'h99; B = 0; MDOp = 2'd2;
      end else begin
        Start = 0; WriteHL = 0;
      end
      #1;
      chk("stall_busy", Stall, 1);
      chk("busy_win", Busy, 1);
      cyc();
    end
    chk("stall_after", Stall, 0);
    chk("repulse_done", Done, 1);
    chk("repulse_hi", HI, 0);
    chk("repulse_lo", LO, 32'd42);
    UseHL = 0;
    cyc();

    // Reset on busy cycle 4 discards the pending divide
    Start = 1; MDOp = 2'd2; A = 32'd100; B = 32'd7;
    cyc();
    Start = 0;
    cyc(); cyc(); cyc();
    chk("busy_c4", Busy, 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("rstb_busy", Busy, 0);
    chk("rstb_hi", HI, 0);
    chk("rstb_lo", LO, 0);
    for (int i = 0; i < 12; i++) begin
      chk("rstb_nodone", Done, 0);
      cyc();
    end

    // Start and WriteHL together: Start wins
    WriteHL = 1; HLSel = 1;
    run_op("startwin", 2'd0, 32'h55, 32'd2, 5, 32'd0, 32'hAA);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      Start   = ($urandom_range(0, 5) == 0);
      WriteHL = ($urandom_range(0, 3) == 0);
      HLSel   = $urandom_range(0, 1);
      UseHL   = $urandom_range(0, 1);
      MDOp    = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: A = 32'h80000000;
        1: A = 32'hFFFFFFFF;
        2: A = $urandom_range(0, 20);
        default: A = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: B = 32'd0;
        1: B = 32'hFFFFFFFF;
        2: B = $urandom_range(1, 9);
        3: B = -$urandom_range(1, 9);
        default: B = $urandom;
      endcase
      cyc();
    end
    reset = 0; Start = 0; WriteHL = 0;
    repeat (12) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  E-stage instruction is mult/multu/div/divu, valid this cycle.
REQ-005 MDOp  input  2  operation: 0 mult, 1 multu, 2 div, 3 divu.
REQ-006 WriteHL  input  1  E-stage mthi/mtlo, valid this cycle.
REQ-007 HLSel  input  1  target of WriteHL: 0 LO, 1 HI.
REQ-008 A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-009 B  input  32  rt operand (divisor / multiplier).
REQ-010 UseHL  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 Busy  output  1  operation in progress.
REQ-012 Stall  output  1  pipeline stall request to the D stage.
REQ-013 Done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-014 HI  output  32  HI register.
REQ-015 LO  output  32  LO register.

Function
REQ-016 The FSM SHALL have two states: IDLE and BUSY.
REQ-017 In IDLE with Start=1, the block SHALL capture A, B and MDOp, load the counter with the latency (mult/multu 5, div/divu 10), and enter BUSY.
REQ-018 Busy SHALL be 1 for exactly the latency count of cycles, starting the cycle after Start.
REQ-019 On the clock edge ending the last BUSY cycle, the block SHALL write HI/LO, return to IDLE and drop Busy.
REQ-020 Done SHALL be 1 for one cycle, the first cycle in which HI/LO show the new result.
REQ-021 mult and multu SHALL produce the 64-bit product of the captured operands (signed and unsigned respectively), with HI = [63:32] and LO = [31:0].
REQ-022 div and divu SHALL produce LO = quotient and HI = remainder.
REQ-023 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-025 On divide by zero (B = 0), the block SHALL run the full 10 cycles and pulse Done, leaving HI and LO unchanged.
REQ-026 In IDLE with WriteHL=1 and Start=0, the block SHALL write A to HI or LO per HLSel on that edge, with no Busy or Done.
REQ-027 If Start and WriteHL are 1 in the same cycle, Start SHALL win and WriteHL SHALL be ignored.
REQ-028 Start and WriteHL SHALL be ignored while in BUSY, with no effect on operands, counter or HI/LO.
REQ-029 Stall SHALL be combinational: Stall = UseHL AND (Busy OR Start).
REQ-030 On the final BUSY cycle (Busy=1), Stall SHALL still assert when UseHL=1.
REQ-031 HI/LO SHALL change only on operation completion, an accepted WriteHL, or reset.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL set state to IDLE, counter to 0, HI to 0, LO to 0, Busy to 0 and Done to 0, and SHALL clear the captured operands.
REQ-033 A reset during BUSY SHALL discard the pending result: no HI/LO write and no Done pulse follow.
REQ-034 Start SHALL be ignored in any cycle where reset=1.

Structure
REQ-035 A shared package SHALL hold the MDOp encodings, the state encoding and the constants MULT_LAT=5 and DIV_LAT=10.
REQ-036 The arithmetic SHALL live in one combinational sub-module, md_compute, which takes the captured operands and MDOp and returns a 64-bit {HI,LO} result plus a div-by-zero flag.
REQ-037 The result SHALL be registered into HI/LO only at completion.
REQ-038 md_sequencer SHALL contain only the FSM, the counter, the operand capture and the HI/LO registers.

Verification
REQ-039 mult: A=0xFFFFFFFE, B=3, Start pulse -> Busy for 5 cycles; next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done=1 for one cycle.
REQ-040 divu: A=7, B=2, then signed div: A=-7, B=2 -> divu gives LO=3, HI=1 after 10 busy cycles; signed div gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-041 div: A=5, B=0, with HI=0x11 and LO=0x22 preset by mthi/mtlo -> 10 busy cycles, Done pulses, HI=0x11 and LO=0x22 unchanged.
REQ-042 mult started, with UseHL=1 held and Start/WriteHL re-pulsed during BUSY -> Stall=1 in the Start cycle and all 5 busy cycles, 0 after; re-pulses have no effect.
REQ-043 div started, then reset=1 on busy cycle 4 -> next cycle Busy=0, HI=LO=0, and no Done for 12 following cycles.
REQ-044 Start=1 and WriteHL=1 (HLSel=1, A=0x55) in the same IDLE cycle -> the operation runs and HI holds the operation result, not 0x55.
